tnn_feature_packer: RTL and testbench



---
 rtl/tnn_feature_packer.sv | 123 ++++++++++++
 tb/tb_tnn_feature_packer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_feature_packer.sv
// Streaming packer: assembles up to five feature words into one a..e vector behind a registered output.
// Define TNN_PACKER_REFSUM_EN to also register the exact pos/neg partial sums and reference decision.
module tnn_feature_packer #(
   parameter int FEAT_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FEAT_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FEAT_W-1:0] out_a,
   output logic [FEAT_W-1:0] out_b,
   output logic [FEAT_W-1:0] out_c,
   output logic [FEAT_W-1:0] out_d,
   output logic [FEAT_W-1:0] out_e,
   output logic [CNT_W-1:0]  vec_count
`ifdef TNN_PACKER_REFSUM_EN
   ,
   output logic [FEAT_W+1:0] out_pos_sum,
   output logic [FEAT_W:0]   out_neg_sum,
   output logic              out_ref
`endif
);

   // Handshakes: a beat moves on a port only in a cycle where its valid and ready are both 1;
   // valid never waits on ready, and held output data stays stable until taken.

   logic [4:0][FEAT_W-1:0] asm_q;
   logic [4:0][FEAT_W-1:0] asm_d;
   logic [4:0][FEAT_W-1:0] hold_q;
   logic [2:0]             idx_q;
   logic [2:0]             idx_d;
   logic                   asm_done_q;
   logic                   asm_done_d;
   logic                   can_xfer;
   logic                   in_fire;
   logic                   out_fire;
   logic                   completes;

   assign can_xfer  = asm_done_q && (!out_valid || out_ready);
   assign in_ready  = !rst && (!asm_done_q || can_xfer);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign completes = in_last || (idx_q == 3'd4);

   // A transfer empties the assembly register, so a word accepted alongside it lands in a fresh slot 0.
   always_comb begin
      asm_d      = can_xfer ? '0 : asm_q;
      idx_d      = idx_q;
      asm_done_d = can_xfer ? 1'b0 : asm_done_q;
      if (in_fire) begin
         asm_d[idx_q] = in_data;
         if (completes) begin
            idx_d      = 3'd0;
            asm_done_d = 1'b1;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         asm_q      <= '0;
         idx_q      <= 3'd0;
         asm_done_q <= 1'b0;
      end else begin
         asm_q      <= asm_d;
         idx_q      <= idx_d;
         asm_done_q <= asm_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q    <= '0;
         out_valid <= 1'b0;
         vec_count <= '0;
      end else begin
         if (can_xfer) begin
            hold_q    <= asm_q;
            out_valid <= 1'b1;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end
         if (out_fire) begin
            vec_count <= vec_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign out_a = hold_q[0];
   assign out_b = hold_q[1];
   assign out_c = hold_q[2];
   assign out_d = hold_q[3];
   assign out_e = hold_q[4];

`ifdef TNN_PACKER_REFSUM_EN
   logic [FEAT_W+1:0] pos_d;
   logic [FEAT_W:0]   neg_d;

   // Widths hold 3*max and 2*max of a feature word, so neither sum can wrap.
   assign pos_d = {2'b00, asm_q[1]} + {2'b00, asm_q[2]} + {2'b00, asm_q[4]};
   assign neg_d = {1'b0, asm_q[0]} + {1'b0, asm_q[3]};

   always_ff @(posedge clk) begin
      if (rst) begin
         out_pos_sum <= '0;
         out_neg_sum <= '0;
         out_ref     <= 1'b0;
      end else if (can_xfer) begin
         out_pos_sum <= pos_d;
         out_neg_sum <= neg_d;
         out_ref     <= ({1'b0, neg_d} < pos_d);
      end
   end
`endif

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Directed bench for tnn_feature_packer; sum/reference checks are active when TNN_PACKER_REFSUM_EN is defined.
module tb_tnn_feature_packer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_a;
   logic [2:0]  out_b;
   logic [2:0]  out_c;
   logic [2:0]  out_d;
   logic [2:0]  out_e;
   logic [15:0] vec_count;
`ifdef TNN_PACKER_REFSUM_EN
   logic [4:0]  out_pos_sum;
   logic [3:0]  out_neg_sum;
   logic        out_ref;
`endif

   int checks;
   int failures;
   int stalls;
   logic [14:0] cap_q[$];

   tnn_feature_packer #(.FEAT_W(3), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_c     (out_c),
      .out_d     (out_d),
      .out_e     (out_e),
      .vec_count (vec_count)
`ifdef TNN_PACKER_REFSUM_EN
      ,
      .out_pos_sum (out_pos_sum),
      .out_neg_sum (out_neg_sum),
      .out_ref     (out_ref)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every vector handed off; handshake values are stable at the falling edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) cap_q.push_back({out_a, out_b, out_c, out_d, out_e});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [2:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n > 0) stalls++;
      if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("out_valid_wait", 32'(out_valid), 32'd1);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      stalls    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 3'd0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      tick(3);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_vec_count", 32'(vec_count), 32'd0);
      chk("rst_slots", 32'({out_a, out_b, out_c, out_d, out_e}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Full sample 1..5
      @(posedge clk);
      #1;
      send_word(3'd1, 1'b0);
      send_word(3'd2, 1'b0);
      send_word(3'd3, 1'b0);
      send_word(3'd4, 1'b0);
      send_word(3'd5, 1'b1);
      wait_out_valid();
      chk("v12345", 32'({out_a, out_b, out_c, out_d, out_e}), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd5}));
`ifdef TNN_PACKER_REFSUM_EN
      chk("v12345_pos", 32'(out_pos_sum), 32'd10);
      chk("v12345_neg", 32'(out_neg_sum), 32'd5);
      chk("v12345_ref", 32'(out_ref), 32'd1);
`endif
      tick(1);
      chk("v12345_count", 32'(vec_count), 32'd1);
      chk("v12345_drained", 32'(out_valid), 32'd0);

      // Early in_last zero-fills remaining slots
      send_word(3'd7, 1'b0);
      send_word(3'd7, 1'b1);
      wait_out_valid();
      chk("v77", 32'({out_a, out_b, out_c, out_d, out_e}), 32'({3'd7, 3'd7, 9'd0}));
`ifdef TNN_PACKER_REFSUM_EN
      chk("v77_pos", 32'(out_pos_sum), 32'd7);
      chk("v77_neg", 32'(out_neg_sum), 32'd7);
      chk("v77_ref", 32'(out_ref), 32'd0);
`endif
      tick(1);
      chk("v77_count", 32'(vec_count), 32'd2);

      // Ten sevens back-to-back: two max-value vectors, no input stall
      cap_q.delete();
      stalls = 0;
      for (int i = 0; i < 10; i++) send_word(3'd7, 1'b0);
      chk("stream_no_stall", 32'(stalls), 32'd0);
`ifdef TNN_PACKER_REFSUM_EN
      wait_out_valid();
      chk("max_pos", 32'(out_pos_sum), 32'd21);
      chk("max_neg", 32'(out_neg_sum), 32'd14);
      chk("max_ref", 32'(out_ref), 32'd1);
`endif
      tick(5);
      chk("stream_vec_num", 32'(cap_q.size()), 32'd2);
      if (cap_q.size() >= 2) begin
         chk("stream_v0", 32'(cap_q[0]), 32'h7FFF);
         chk("stream_v1", 32'(cap_q[1]), 32'h7FFF);
      end
      chk("stream_count", 32'(vec_count), 32'd4);

      // Backpressure: vector 1 held, vector 2 stalls in assembly
      out_ready = 1'b0;
      send_word(3'd1, 1'b0);
      send_word(3'd2, 1'b0);
      send_word(3'd3, 1'b0);
      send_word(3'd4, 1'b0);
      send_word(3'd5, 1'b0);
      send_word(3'd6, 1'b0);
      send_word(3'd7, 1'b0);
      send_word(3'd1, 1'b0);
      send_word(3'd2, 1'b0);
      send_word(3'd3, 1'b0);
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_hold_v1", 32'({out_a, out_b, out_c, out_d, out_e}), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd5}));
      tick(3);
      @(negedge clk);
      chk("bp_still_valid", 32'(out_valid), 32'd1);
      chk("bp_stable_v1", 32'({out_a, out_b, out_c, out_d, out_e}), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd5}));
      chk("bp_count_held", 32'(vec_count), 32'd4);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_resume_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_v2_valid", 32'(out_valid), 32'd1);
      chk("bp_v2", 32'({out_a, out_b, out_c, out_d, out_e}), 32'({3'd6, 3'd7, 3'd1, 3'd2, 3'd3}));
      chk("bp_count_one", 32'(vec_count), 32'd5);
      out_ready = 1'b1;
      tick(3);
      chk("bp_count_drain", 32'(vec_count), 32'd6);

      // Reset mid-hold and mid-sample discards everything
      out_ready = 1'b0;
      send_word(3'd1, 1'b0);
      send_word(3'd2, 1'b0);
      send_word(3'd3, 1'b0);
      send_word(3'd4, 1'b0);
      send_word(3'd5, 1'b1);
      send_word(3'd6, 1'b0);
      send_word(3'd6, 1'b0);
      send_word(3'd6, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_count", 32'(vec_count), 32'd0);
      chk("mid_rst_slots", 32'({out_a, out_b, out_c, out_d, out_e}), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send_word(3'd5, 1'b0);
      send_word(3'd0, 1'b0);
      send_word(3'd0, 1'b0);
      send_word(3'd0, 1'b0);
      send_word(3'd0, 1'b1);
      wait_out_valid();
      chk("post_rst_v", 32'({out_a, out_b, out_c, out_d, out_e}), 32'({3'd5, 12'd0}));
`ifdef TNN_PACKER_REFSUM_EN
      chk("post_rst_pos", 32'(out_pos_sum), 32'd0);
      chk("post_rst_neg", 32'(out_neg_sum), 32'd5);
      chk("post_rst_ref", 32'(out_ref), 32'd0);
`endif
      tick(2);
      chk("post_rst_count", 32'(vec_count), 32'd1);

      // Counter wrap: single-word samples bring vec_count to 0xFFFF, then one more
      for (int i = 0; i < 65534; i++) begin
         send_word(3'(i), 1'b1);
         if (cap_q.size() > 16) cap_q.delete();
      end
      tick(4);
      chk("count_ffff", 32'(vec_count), 32'h0000FFFF);
      send_word(3'd3, 1'b1);
      tick(4);
      chk("count_wrap", 32'(vec_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
